// File: rtl/conv_pkg.sv
// Shared types and width helpers for the parametrised streaming convolution engine.
package conv_pkg;

  typedef enum logic {
    LINEAR   = 1'b0,
    CIRCULAR = 1'b1
  } conv_mode_e;

  typedef enum logic {
    LOAD    = 1'b0,
    COMPUTE = 1'b1
  } conv_state_e;

  // Sum of N products of two DIN_W-bit values never exceeds this width.
  function automatic int acc_width(input int din_w, input int n);
    return 2 * din_w + $clog2(n);
  endfunction

  // Counter over the 2N input samples; also wide enough for the 2N-1 output index.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n);
  endfunction

  // Index into the N-entry x/h arrays.
  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Single serial multiply-accumulate. acc presents the running sum including the
// current enabled term, so the parent can register a complete result on the last term.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DIN_W = 4,
  parameter int ACC_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [DIN_W-1:0] a,
  input  logic [DIN_W-1:0] b,
  output logic [ACC_W-1:0] acc
);

  logic [2*DIN_W-1:0] prod_s;
  logic [ACC_W-1:0]   acc_r;

  // Product and running sum including this cycle's term.
  always_comb begin
    prod_s = {{DIN_W{1'b0}}, a} * {{DIN_W{1'b0}}, b};
    if (en) begin
      acc = acc_r + ACC_W'(prod_s);
    end else begin
      acc = acc_r;
    end
  end

  // Accumulator register; clear wins so a result boundary starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (clear) begin
      acc_r <= {ACC_W{1'b0}};
    end else begin
      acc_r <= acc;
    end
  end

endmodule

// File: rtl/conv_param.sv
// Streaming 1-D convolution: loads x then h serially, then emits one linear or
// circular convolution result every N cycles from a single serial MAC.
module conv_param
  import conv_pkg::*;
#(
  parameter int DIN_W  = 4,
  parameter int N      = 8,
  parameter int DOUT_W = 8,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIN_W-1:0]  Din,
  input  logic              in_en,
  input  logic              mode,
  output logic              busy,
  output logic              out_valid,
  output logic [DOUT_W-1:0] Dout
);

  localparam int ACC_W = acc_width(DIN_W, N);
  localparam int CW    = cnt_width(N);
  localparam int IW    = idx_width(N);
  localparam int WW    = ACC_W + DOUT_W;

  localparam logic [CW-1:0] N_C        = CW'(N);
  localparam logic [CW-1:0] LAST_IN    = CW'(2 * N - 1);
  localparam logic [CW-1:0] K_LIN_LAST = CW'(2 * N - 2);
  localparam logic [CW-1:0] K_CIR_LAST = CW'(N - 1);
  localparam logic [IW-1:0] LAST_I     = IW'(N - 1);

  conv_state_e       state_r, next_s;
  conv_mode_e        mode_r;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     k_r;
  logic [IW-1:0]     i_r;
  logic [DIN_W-1:0]  x_r [N];
  logic [DIN_W-1:0]  h_r [N];
  logic              out_valid_r;
  logic [DOUT_W-1:0] dout_r;

  logic              busy_s, accept_s, last_in_s, last_term_s, last_out_s;
  logic [CW-1:0]     k_last_s, i_ext_s, diff_s, wrap_s, ld_s;
  logic [IW-1:0]     hidx_s, ld_idx_s;
  logic              term_ok_s;
  logic [ACC_W-1:0]  acc_s;
  logic [WW-1:0]     wide_s, max_s;
  logic [DOUT_W-1:0] res_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LOAD;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      LOAD:    next_s = last_in_s  ? COMPUTE : LOAD;
      COMPUTE: next_s = last_out_s ? LOAD    : COMPUTE;
      default: next_s = LOAD;
    endcase
  end

  // FSM-derived control strobes.
  always_comb begin
    busy_s      = (state_r == COMPUTE);
    accept_s    = (state_r == LOAD) && in_en;
    last_in_s   = accept_s && (cnt_r == LAST_IN);
    k_last_s    = (mode_r == CIRCULAR) ? K_CIR_LAST : K_LIN_LAST;
    last_term_s = busy_s && (i_r == LAST_I);
    last_out_s  = last_term_s && (k_r == k_last_s);
  end

  // h index for term i of output k; linear drops terms with k-i outside 0..N-1.
  always_comb begin
    i_ext_s = CW'(i_r);
    diff_s  = k_r - i_ext_s;
    wrap_s  = diff_s + N_C;
    if (k_r >= i_ext_s) begin
      term_ok_s = (mode_r == CIRCULAR) || (diff_s < N_C);
      hidx_s    = diff_s[IW-1:0];
    end else begin
      term_ok_s = (mode_r == CIRCULAR);
      hidx_s    = wrap_s[IW-1:0];
    end
    ld_s     = (cnt_r < N_C) ? cnt_r : (cnt_r - N_C);
    ld_idx_s = ld_s[IW-1:0];
  end

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      if (cnt_r < N_C) begin
        x_r[ld_idx_s] <= Din;
      end else begin
        h_r[ld_idx_s] <= Din;
      end
    end
  end

  // Input counter, mode capture and output/term indices.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= {CW{1'b0}};
      k_r    <= {CW{1'b0}};
      i_r    <= {IW{1'b0}};
      mode_r <= LINEAR;
    end else begin
      case (state_r)
        LOAD: begin
          if (accept_s) begin
            if (cnt_r == {CW{1'b0}}) begin
              mode_r <= conv_mode_e'(mode);
            end
            cnt_r <= last_in_s ? {CW{1'b0}} : (cnt_r + {{(CW-1){1'b0}}, 1'b1});
          end
          k_r <= {CW{1'b0}};
          i_r <= {IW{1'b0}};
        end
        COMPUTE: begin
          if (last_term_s) begin
            i_r <= {IW{1'b0}};
            k_r <= last_out_s ? {CW{1'b0}} : (k_r + {{(CW-1){1'b0}}, 1'b1});
          end else begin
            i_r <= i_r + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
          k_r   <= {CW{1'b0}};
          i_r   <= {IW{1'b0}};
        end
      endcase
    end
  end

  conv_mac #(
    .DIN_W(DIN_W),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clear(last_term_s),
    .en   (busy_s && term_ok_s),
    .a    (x_r[i_r]),
    .b    (h_r[hidx_s]),
    .acc  (acc_s)
  );

  // Saturate or wrap the completed sum to the output width.
  always_comb begin
    wide_s = WW'(acc_s);
    max_s  = WW'({DOUT_W{1'b1}});
    if ((SAT != 0) && (wide_s > max_s)) begin
      res_s = {DOUT_W{1'b1}};
    end else begin
      res_s = wide_s[DOUT_W-1:0];
    end
  end

  // Result register and one-cycle strobe; Dout holds between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      dout_r      <= {DOUT_W{1'b0}};
    end else begin
      out_valid_r <= last_term_s;
      if (last_term_s) begin
        dout_r <= res_s;
      end
    end
  end

  assign busy      = busy_s;
  assign out_valid = out_valid_r;
  assign Dout      = dout_r;

endmodule

// File: tb/tb_conv_param.sv
// Self-checking bench for conv_param: wrap and saturating instances driven in
// parallel and compared every cycle against a frame-level convolution model.
module tb_conv_param;

  localparam int N      = 8;
  localparam int DIN_W  = 4;
  localparam int DOUT_W = 8;
  localparam int DMAX   = (1 << DOUT_W) - 1;

  logic              clk = 1'b0;
  logic              reset, in_en, mode;
  logic [DIN_W-1:0]  Din;
  logic              busy, out_valid, busy_sat, out_valid_sat;
  logic [DOUT_W-1:0] Dout, Dout_sat;

  conv_param #(.DIN_W(DIN_W), .N(N), .DOUT_W(DOUT_W), .SAT(0)) dut (
    .clk(clk), .reset(reset), .Din(Din), .in_en(in_en), .mode(mode),
    .busy(busy), .out_valid(out_valid), .Dout(Dout)
  );

  conv_param #(.DIN_W(DIN_W), .N(N), .DOUT_W(DOUT_W), .SAT(1)) dut_sat (
    .clk(clk), .reset(reset), .Din(Din), .in_en(in_en), .mode(mode),
    .busy(busy_sat), .out_valid(out_valid_sat), .Dout(Dout_sat)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int mx[N];
  int mh[N];
  int yq[$];
  int m_cnt, m_c, m_k;
  bit m_busy, m_mode;
  bit exp_v;
  int exp_d, exp_ds;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wrapv(input int s);
    return s % (DMAX + 1);
  endfunction

  function automatic int satv(input int s);
    return (s > DMAX) ? DMAX : s;
  endfunction

  // Convolution of the captured frame straight from its definition.
  task automatic compute_frame();
    int s, j;
    yq.delete();
    m_k = m_mode ? N : 2 * N - 1;
    for (int k = 0; k < m_k; k++) begin
      s = 0;
      for (int i = 0; i < N; i++) begin
        if (m_mode) begin
          j = (k - i + N) % N;
          s += mx[i] * mh[j];
        end else begin
          j = k - i;
          if (j >= 0 && j < N) s += mx[i] * mh[j];
        end
      end
      yq.push_back(s);
    end
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, exp_v);
    chk("dout_wrap", Dout, exp_d);
    chk("busy_sat", busy_sat, m_busy);
    chk("out_valid_sat", out_valid_sat, exp_v);
    chk("dout_sat", Dout_sat, exp_ds);
  endtask

  // One clock: check, drive, then advance the model across the edge.
  task automatic step(input int d, input bit en, input bit md);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    Din   = d[DIN_W-1:0];
    in_en = en;
    mode  = md;
    @(posedge clk);
    exp_v = 1'b0;
    if (!m_busy) begin
      if (en) begin
        if (m_cnt < N) mx[m_cnt] = d % (1 << DIN_W);
        else mh[m_cnt - N] = d % (1 << DIN_W);
        if (m_cnt == 0) m_mode = md;
        if (m_cnt == 2 * N - 1) begin
          compute_frame();
          m_busy = 1'b1;
          m_c    = 0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end else begin
      m_c++;
      if (m_c % N == 0) begin
        exp_v  = 1'b1;
        exp_d  = wrapv(yq[m_c / N - 1]);
        exp_ds = satv(yq[m_c / N - 1]);
      end
      if (m_c == N * m_k) m_busy = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_cnt  = 0;
    m_c    = 0;
    exp_v  = 1'b0;
    exp_d  = 0;
    exp_ds = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    in_en = 1'b0;
    @(posedge clk);
    model_reset();
  endtask

  task automatic load_frame(input int v[2*N], input bit md);
    for (int s = 0; s < 2 * N; s++) step(v[s], 1'b1, md);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(0, 1'b0, 1'b0);
  endtask

  int f[2*N];
  int imp[2*N];

  initial begin
    reset = 1'b1;
    in_en = 1'b0;
    mode  = 1'b0;
    Din   = '0;
    m_mode = 1'b0;
    m_k    = 2 * N - 1;
    @(posedge clk);
    @(posedge clk);
    model_reset();

    // Linear and circular all-ones frames.
    for (int s = 0; s < 2 * N; s++) f[s] = 1;
    load_frame(f, 1'b0);
    idle(N * (2 * N - 1) + 2);
    load_frame(f, 1'b1);
    idle(N * N + 2);

    // Full-scale samples exercise wrap versus saturation.
    for (int s = 0; s < 2 * N; s++) f[s] = 15;
    load_frame(f, 1'b0);
    idle(N * (2 * N - 1) + 2);

    // Impulse response.
    imp = '{1, 0, 0, 0, 0, 0, 0, 0, 3, 1, 4, 1, 5, 9, 2, 6};
    load_frame(imp, 1'b0);
    idle(N * (2 * N - 1) + 2);

    // in_en held high across back-to-back frames with random data and mode.
    for (int c = 0; c < 3 * (2 * N + N * (2 * N - 1)); c++)
      step($urandom_range(0, 15), 1'b1, 1'($urandom_range(0, 1)));
    idle(N * (2 * N - 1) + 2);

    // Sparse random in_en.
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 15), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    idle(N * (2 * N - 1) + 2);

    // Reset after the third strobe, then a fresh all-ones linear frame.
    for (int s = 0; s < 2 * N; s++) f[s] = 1;
    load_frame(f, 1'b0);
    idle(3 * N);
    do_reset();
    load_frame(f, 1'b0);
    idle(N * (2 * N - 1) + 2);

    @(negedge clk);
    check_outputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
